// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding and
// the multdiv timeout limit.
package hazard_ctrl_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MD_WAIT = 1'b1
    } hz_state_t;

    localparam int          MD_CNT_W   = 6;
    localparam logic [5:0]  MD_TIMEOUT = 6'd63;
    localparam int          STALL_W    = 32;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side signals seen by the hazard controller. The pipeline
// (master) drives decode info; the controller (slave) drives enables.
interface hazard_if;
    logic [4:0]  fd_rs;
    logic [4:0]  fd_rt;
    logic        fd_uses_rs;
    logic        fd_uses_rt;
    logic [4:0]  dx_rd;
    logic        dx_is_load;
    logic        dx_is_mult;
    logic        dx_is_div;
    logic        x_branch_taken;
    logic        md_ready;

    logic        pc_we;
    logic        fd_we;
    logic        dx_we;
    logic        fd_flush;
    logic        dx_flush;
    logic        xm_flush;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic        md_exception;
    logic [31:0] stall_count;

    modport master (
        output fd_rs, fd_rt, fd_uses_rs, fd_uses_rt, dx_rd, dx_is_load,
               dx_is_mult, dx_is_div, x_branch_taken, md_ready,
        input  pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush,
               md_ctrl_mult, md_ctrl_div, md_exception, stall_count
    );

    modport slave (
        input  fd_rs, fd_rt, fd_uses_rs, fd_uses_rt, dx_rd, dx_is_load,
               dx_is_mult, dx_is_div, x_branch_taken, md_ready,
        output pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush,
               md_ctrl_mult, md_ctrl_div, md_exception, stall_count
    );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use detector: a load in D/X feeding a source of the F/D instruction.
module hazard_ctrl_detect (
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rs,
    input  logic       fd_uses_rt,
    input  logic [4:0] dx_rd,
    input  logic       dx_is_load,
    output logic       load_use
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = fd_uses_rs && (fd_rs == dx_rd);
    assign rt_hit   = fd_uses_rt && (fd_rt == dx_rd);
    // r0 is hardwired zero, so a load targeting it never produces a value
    assign load_use = dx_is_load && (dx_rd != 5'd0) && (rs_hit || rt_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multdiv sequencing with timeout, branch
// flush, load-use bubble and a saturating stall counter.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | normal issue; decode multdiv start, branch, load-use
//   ST_MD_WAIT | multdiv running; freeze front end until ready/timeout
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      clr,
    hazard_if.slave   bus
);
    hz_state_t             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0]    stall_q;
    logic                  load_use;
    logic                  pc_we, fd_we, dx_we;
    logic                  fd_flush, dx_flush, xm_flush;
    logic                  md_mult, md_div, md_exc;

    hazard_ctrl_detect u_detect (
        .fd_rs      (bus.fd_rs),
        .fd_rt      (bus.fd_rt),
        .fd_uses_rs (bus.fd_uses_rs),
        .fd_uses_rt (bus.fd_uses_rt),
        .dx_rd      (bus.dx_rd),
        .dx_is_load (bus.dx_is_load),
        .load_use   (load_use)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_we && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_we    = 1'b1;
        fd_we    = 1'b1;
        dx_we    = 1'b1;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_flush = 1'b0;
        md_mult  = 1'b0;
        md_div   = 1'b0;
        md_exc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dx_is_mult || bus.dx_is_div) begin
                    md_mult  = bus.dx_is_mult;
                    md_div   = bus.dx_is_div;
                    pc_we    = 1'b0;
                    fd_we    = 1'b0;
                    dx_we    = 1'b0;
                    xm_flush = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_MD_WAIT;
                end else if (bus.x_branch_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (load_use) begin
                    pc_we    = 1'b0;
                    fd_we    = 1'b0;
                    dx_flush = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (bus.md_ready) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == MD_TIMEOUT) begin
                    md_exc  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    pc_we    = 1'b0;
                    fd_we    = 1'b0;
                    dx_we    = 1'b0;
                    xm_flush = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pc_we        = pc_we;
    assign bus.fd_we        = fd_we;
    assign bus.dx_we        = dx_we;
    assign bus.fd_flush     = fd_flush;
    assign bus.dx_flush     = dx_flush;
    assign bus.xm_flush     = xm_flush;
    assign bus.md_ctrl_mult = md_mult;
    assign bus.md_ctrl_div  = md_div;
    assign bus.md_exception = md_exc;
    assign bus.stall_count  = stall_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed corner cases followed by
// random traffic, checked against a rule-level reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    hazard_if hif ();

    hazard_ctrl dut (
        .clk (clk),
        .clr (clr),
        .bus (hif)
    );

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic urs, urt, load, mult, div, br, rdy, clr;
    } stim_t;

    typedef struct {
        logic        pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush;
        logic        md_mult, md_div, md_exc;
        logic [31:0] stall;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    bit          m_busy   = 1'b0;
    int          m_waited = 0;
    logic [31:0] m_stall  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{rs: 5'd1, rt: 5'd2, rd: 5'd3, urs: 1'b0, urt: 1'b0, load: 1'b0,
              mult: 1'b0, div: 1'b0, br: 1'b0, rdy: 1'b0, clr: 1'b0};
        return s;
    endfunction

    // Issue one cycle: drive, predict, push, advance model, step clock.
    task automatic cyc(input stim_t s);
        exp_t e;
        bit   hazard;
        hif.fd_rs          = s.rs;
        hif.fd_rt          = s.rt;
        hif.fd_uses_rs     = s.urs;
        hif.fd_uses_rt     = s.urt;
        hif.dx_rd          = s.rd;
        hif.dx_is_load     = s.load;
        hif.dx_is_mult     = s.mult;
        hif.dx_is_div      = s.div;
        hif.x_branch_taken = s.br;
        hif.md_ready       = s.rdy;
        clr                = s.clr;

        e = '{pc_we: 1, fd_we: 1, dx_we: 1, fd_flush: 0, dx_flush: 0, xm_flush: 0,
              md_mult: 0, md_div: 0, md_exc: 0, stall: m_stall};
        hazard = s.load && s.rd != 0 &&
                 ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
        if (!m_busy) begin
            if (s.mult || s.div) begin
                e.md_mult = s.mult; e.md_div = s.div;
                e.pc_we = 0; e.fd_we = 0; e.dx_we = 0; e.xm_flush = 1;
                m_busy = 1; m_waited = 0;
            end else if (s.br) begin
                e.fd_flush = 1; e.dx_flush = 1;
            end else if (hazard) begin
                e.pc_we = 0; e.fd_we = 0; e.dx_flush = 1;
            end
        end else begin
            if (s.rdy) begin
                m_busy = 0;
            end else if (m_waited == 63) begin
                e.md_exc = 1; m_busy = 0;
            end else begin
                e.pc_we = 0; e.fd_we = 0; e.dx_we = 0; e.xm_flush = 1;
                m_waited++;
            end
        end
        sbq.push_back(e);

        if (s.clr) begin
            m_busy = 0; m_waited = 0; m_stall = '0;
        end else if (!e.pc_we && m_stall != 32'hFFFF_FFFF) begin
            m_stall = m_stall + 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pc_we",        hif.pc_we,        e.pc_we);
                chk("fd_we",        hif.fd_we,        e.fd_we);
                chk("dx_we",        hif.dx_we,        e.dx_we);
                chk("fd_flush",     hif.fd_flush,     e.fd_flush);
                chk("dx_flush",     hif.dx_flush,     e.dx_flush);
                chk("xm_flush",     hif.xm_flush,     e.xm_flush);
                chk("md_ctrl_mult", hif.md_ctrl_mult, e.md_mult);
                chk("md_ctrl_div",  hif.md_ctrl_div,  e.md_div);
                chk("md_exception", hif.md_exception, e.md_exc);
                chk("stall_count",  hif.stall_count,  e.stall);
            end
        end
    end

    initial begin
        stim_t s;
        int    sel;
        s = nop();
        s.clr = 1;
        hif.fd_rs = '0; hif.fd_rt = '0; hif.fd_uses_rs = 0; hif.fd_uses_rt = 0;
        hif.dx_rd = '0; hif.dx_is_load = 0; hif.dx_is_mult = 0; hif.dx_is_div = 0;
        hif.x_branch_taken = 0; hif.md_ready = 0;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state with clr still high
        cyc(s);
        cyc(nop());

        // load-use on rs: one bubble
        s = nop(); s.load = 1; s.rd = 5'd5; s.rs = 5'd5; s.urs = 1;
        cyc(s);
        chk("loaduse_stall_count", hif.stall_count, 32'd1);
        cyc(nop());

        // load to r0 never stalls
        s = nop(); s.load = 1; s.rd = 5'd0; s.rs = 5'd0; s.urs = 1;
        cyc(s);

        // branch overrides load-use
        s = nop(); s.load = 1; s.rd = 5'd7; s.rt = 5'd7; s.urt = 1; s.br = 1;
        cyc(s);
        chk("branch_stall_count", hif.stall_count, 32'd1);

        // mult, ready 10 cycles after issue
        s = nop(); s.clr = 1; cyc(s);
        s = nop(); s.mult = 1;
        repeat (10) cyc(s);
        s.rdy = 1; cyc(s);
        chk("mult_stall_count", hif.stall_count, 32'd10);
        cyc(nop());

        // div that never completes: timeout
        s = nop(); s.clr = 1; cyc(s);
        s = nop(); s.div = 1;
        repeat (65) cyc(s);
        chk("div_timeout_stall_count", hif.stall_count, 32'd64);
        cyc(nop());

        // clr mid-wait
        s = nop(); s.mult = 1;
        repeat (6) cyc(s);
        s.clr = 1; cyc(s);
        chk("clr_midwait_stall_count", hif.stall_count, 32'd0);
        repeat (3) cyc(nop());

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rs   = 5'($urandom_range(0, 3));
            s.rt   = 5'($urandom_range(0, 3));
            s.rd   = 5'($urandom_range(0, 3));
            s.urs  = 1'($urandom % 2);
            s.urt  = 1'($urandom % 2);
            s.load = ($urandom % 3) == 0;
            sel    = int'($urandom % 10);
            s.mult = (sel == 0);
            s.div  = (sel == 1);
            s.br   = ($urandom % 5) == 0;
            s.rdy  = ($urandom % 8) == 0;
            s.clr  = ($urandom % 150) == 0;
            cyc(s);
        end

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 clr  input  1  reset, synchronous, active-high.
REQ-003 fd_rs, fd_rt  input  5 each  source register numbers of the instruction in F/D.
REQ-004 fd_uses_rs, fd_uses_rt  input  1 each  F/D instruction reads rs / rt.
REQ-005 dx_rd  input  5  destination register of the D/X instruction.
REQ-006 dx_is_load  input  1  D/X instruction is lw.
REQ-007 dx_is_mult, dx_is_div  input  1 each  D/X instruction is mul / div; never both high.
REQ-008 x_branch_taken  input  1  branch/jump resolved taken in X this cycle.
REQ-009 md_ready  input  1  multdiv unit result valid.
REQ-010 pc_we, fd_we, dx_we  output  1 each  write enables for PC, F/D and D/X latches.
REQ-011 fd_flush, dx_flush, xm_flush  output  1 each  load a nop into that latch at the next edge.
REQ-012 md_ctrl_mult, md_ctrl_div  output  1 each  single-cycle start pulses to the multdiv unit.
REQ-013 md_exception  output  1  one-cycle pulse on multdiv timeout.
REQ-014 stall_count  output  32  cycles with pc_we=0 since reset.

Function
REQ-015 States: IDLE, MD_WAIT; only sequential state is the state register, a 6-bit timeout counter and stall_count.
REQ-016 Default when no condition below applies: pc_we=fd_we=dx_we=1, all flushes 0, all pulses 0.
REQ-017 IDLE with dx_is_mult or dx_is_div: assert the matching md_ctrl pulse this cycle (combinational); pc_we=fd_we=dx_we=0; xm_flush=1; next state MD_WAIT; counter cleared to 0.
REQ-018 MD_WAIT with md_ready=0 and counter<63: pc_we=fd_we=dx_we=0, xm_flush=1, counter increments, stay in MD_WAIT.
REQ-019 MD_WAIT with md_ready=1: default enables (pipeline advances, X/M captures result), next state IDLE.
REQ-020 MD_WAIT with md_ready=0 and counter=63: md_exception=1, default enables, next state IDLE.
REQ-021 md_ctrl pulses never asserted in MD_WAIT; exactly one pulse per multdiv instruction.
REQ-022 Load-use (IDLE only, no multdiv in D/X): dx_is_load, dx_rd!=0, and (fd_uses_rs and fd_rs==dx_rd or fd_uses_rt and fd_rt==dx_rd) -> pc_we=0, fd_we=0, dx_flush=1; exactly one bubble.
REQ-023 Branch (IDLE only): x_branch_taken -> pc_we=1, fd_flush=1, dx_flush=1; overrides load-use in the same cycle.
REQ-024 Priority: multdiv sequencing > branch > load-use > default.
REQ-025 Register 0 never causes a load-use stall.
REQ-026 stall_count increments every cycle pc_we=0; saturates at 32'hFFFF_FFFF.
REQ-027 All outputs other than stall_count are combinational from state, counter and inputs; no output depends on clr combinationally except through state.

Reset
REQ-028 clr=1 at a rising edge: state=IDLE, counter=0, stall_count=0; takes effect regardless of state, including mid-MD_WAIT (no md_exception generated).
REQ-029 While clr=1, outputs follow IDLE decode of current inputs; pipeline latches are cleared by their own clr.

Structure
REQ-030 State encoding constants and the timeout limit (63) live in a shared package/include used by the processor top.
REQ-031 Single module; no sub-module required, optional stall-detect combinational helper hazard_detect.

Verification
REQ-032 Load-use: dx_is_load=1, dx_rd=5, fd_rs=5, fd_uses_rs=1 -> one cycle pc_we=0, fd_we=0, dx_flush=1; stall_count=1.
REQ-033 dx_rd=0 with matching fd_rs=0 and load -> no stall.
REQ-034 Branch plus load-use same cycle -> pc_we=1, fd_flush=1, dx_flush=1, stall_count unchanged.
REQ-035 dx_is_mult=1, md_ready high 10 cycles later -> md_ctrl_mult one pulse, 10 stall cycles with xm_flush=1, release on ready cycle, stall_count=10.
REQ-036 dx_is_div=1, md_ready never -> md_exception pulse on 64th cycle, return to IDLE.
REQ-037 clr asserted mid-MD_WAIT -> IDLE next cycle, stall_count=0, no md_exception.
